// File: rtl/bus_trace.sv
// bus_trace: 8080 machine-cycle tracer. Captures {status, address} on each
// sync rising edge, filters on masked status bits, triggers on an address
// match and buffers entries in a FIFO drained by a debug host.
// Optional feature: define BUS_TRACE_TIMESTAMP_EN to prepend a 16-bit
// free-running timestamp to each entry (rd_data grows from 24 to 40 bits).
module bus_trace #(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned POST_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync,
    input  logic [7:0]        mon_data,
    input  logic [15:0]       mon_addr,
    input  logic              arm,
    input  logic              abort,
    input  logic [15:0]       trig_addr,
    input  logic [7:0]        st_mask,
    input  logic [7:0]        st_match,
    input  logic [POST_W-1:0] post_count,
    input  logic              rd_en,
`ifdef BUS_TRACE_TIMESTAMP_EN
    output logic [39:0]       rd_data,
`else
    output logic [23:0]       rd_data,
`endif
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic [1:0]        state
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned ENTRY_W = $bits(rd_data);
    localparam int unsigned PTR_W   = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             st, st_n;
    logic               sync_d;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] wdata, head_n;
    logic [POST_W-1:0]  cnt, cnt_n;
    logic               ovf_n, ev, hit, trig, do_pop, push, space;
    logic               wr_en, drop_old, flush;

`ifdef BUS_TRACE_TIMESTAMP_EN
    logic [15:0] ts;

    // Free-running timestamp, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ts <= '0;
        else        ts <= ts + 16'd1;
    end

    assign wdata = {ts, mon_data, mon_addr};
`else
    assign wdata = {mon_data, mon_addr};
`endif

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign state = st;

    assign ev     = sync & ~sync_d;
    assign hit    = ((mon_data ^ st_match) & st_mask) == '0;
    assign trig   = (mon_addr == trig_addr);
    assign do_pop = rd_en & ~empty;
    assign space  = ~full | do_pop;

    // Next-state, counter, FIFO pointer and head computation.
    always_comb begin
        st_n     = st;
        cnt_n    = cnt;
        ovf_n    = overflow;
        push     = 1'b0;
        flush    = 1'b0;
        if (arm) begin
            flush = 1'b1;
            st_n  = ARMED;
            ovf_n = 1'b0;
            cnt_n = (post_count == '0) ? POST_W'(1) : post_count;
        end else if (abort) begin
            st_n = IDLE;
        end else if (ev) begin
            case (st)
                ARMED: begin
                    if (trig) begin
                        push  = 1'b1;
                        cnt_n = cnt - POST_W'(1);
                        st_n  = (cnt <= POST_W'(1)) ? DONE : CAPTURE;
                    end else if (hit) begin
                        push = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (hit) begin
                        push  = 1'b1;
                        cnt_n = cnt - POST_W'(1);
                        if (cnt <= POST_W'(1)) st_n = DONE;
                    end
                end
                default: ;
            endcase
        end

        // Pre-trigger ring drops the oldest entry; during capture a full FIFO
        // drops the new entry and flags overflow.
        drop_old = push & ~space & (st == ARMED);
        wr_en    = push & (space | (st == ARMED));
        if (push & ~space & (st == CAPTURE)) ovf_n = 1'b1;

        if (flush) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
        end else begin
            wr_ptr_n = wr_ptr + PTR_W'(wr_en);
            rd_ptr_n = rd_ptr + PTR_W'(do_pop | drop_old);
        end

        // Head bypass: if the new head is the slot being written this clock,
        // forward the write data instead of the stale array contents.
        if (wr_en && (rd_ptr_n[DEPTH_LOG2-1:0] == wr_ptr[DEPTH_LOG2-1:0]))
            head_n = wdata;
        else
            head_n = mem[rd_ptr_n[DEPTH_LOG2-1:0]];
    end

    // Control registers and registered FIFO head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_d   <= 1'b0;
            st       <= IDLE;
            cnt      <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
        end else begin
            sync_d   <= sync;
            st       <= st_n;
            cnt      <= cnt_n;
            overflow <= ovf_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            if (flush)                     rd_data <= '0;
            else if (rd_ptr_n != wr_ptr_n) rd_data <= head_n;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
    end

endmodule
